// File: rtl/adc_frame_packer_pkg.sv
// Shared definitions for the ADC frame packer: header magic, FSM state encodings, word formats.
// The downstream DDR readout and host software decode frames against these same values.
// Optional feature macro: TIMESTAMP_EN (adds a timestamp word after each header).
package adc_frame_packer_pkg;

  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

`ifdef TIMESTAMP_EN
  localparam int unsigned HDR_WORDS = 2;
`else
  localparam int unsigned HDR_WORDS = 1;
`endif

  // StHdr is a reserved encoding kept for decoder compatibility; the header is written
  // directly from StIdle on the admitting cycle.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr  = 3'd1,
    StTs   = 3'd2,
    StData = 3'd3,
    StDrop = 3'd4
  } state_e;

  function automatic logic [31:0] make_header(input logic [15:0] frame_idx);
    return {HDR_MAGIC, frame_idx};
  endfunction

  function automatic logic [31:0] make_data(input logic [15:0] smp_a, input logic [15:0] smp_b);
    return {smp_b, smp_a};
  endfunction

endpackage

// File: rtl/daq_timestamp_ctr.sv
// Free-running 32-bit cycle counter with enable and synchronous active-low reset.
// Ports:
//   clk_i     clock
//   reset_ni  synchronous reset, active low
//   en_i      count enable
//   count_o   current count, wraps at 2^32
module daq_timestamp_ctr (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count_q <= 32'd0;
    end else if (en_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/adc_frame_packer.sv
// Packs paired 16-bit ADC samples into framed 32-bit words for the DDR2 input FIFO.
// A frame is a header word ({A5A5, frame index}), an optional timestamp word, then
// FRAME_LEN data words ({sample_b, sample_a}). Frames that would not fit are dropped whole.
// Optional feature macro: TIMESTAMP_EN (timestamp word + daq_timestamp_ctr instance).
// Ports:
//   clk, reset_n (sync, active low), enable (sampled at frame start),
//   sample_vld/sample_a/sample_b (sample pair strobe), fifo_count (FIFO fill level),
//   fifo_we/fifo_din (FIFO write), frame_cnt, drop_cnt (saturating),
//   overflow (sticky drop flag), proto_err (sticky sample spacing violation).
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = 32,
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter int unsigned FILL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_vld,
  input  logic [15:0] sample_a,
  input  logic [15:0] sample_b,
  input  logic [9:0]  fifo_count,
  output logic        fifo_we,
  output logic [31:0] fifo_din,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  output logic        proto_err
);

  localparam int unsigned NeedWords = FRAME_LEN + HDR_WORDS + FILL_MARGIN;
  localparam logic [9:0]  LastWord  = 10'(FRAME_LEN - 1);

  state_e      state_q;
  logic [9:0]  word_cnt_q;
  logic [31:0] hold_q;
  logic        hold_vld_q;
  logic        fifo_we_q;
  logic [31:0] fifo_din_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        overflow_q;
  logic        proto_err_q;

  logic [10:0] free_words;
  logic        admit;

  // fifo_count never exceeds FIFO_DEPTH-1, so the 11-bit difference cannot wrap.
  assign free_words = 11'(FIFO_DEPTH) - {1'b0, fifo_count};
  assign admit      = ({1'b0, free_words} >= 12'(NeedWords));

`ifdef TIMESTAMP_EN
  logic [31:0] ts_now;
  logic [31:0] ts_q;

  daq_timestamp_ctr u_ts_ctr (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .en_i     (1'b1),
    .count_o  (ts_now)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      word_cnt_q  <= 10'd0;
      hold_q      <= 32'd0;
      hold_vld_q  <= 1'b0;
      fifo_we_q   <= 1'b0;
      fifo_din_q  <= 32'd0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef TIMESTAMP_EN
      ts_q        <= 32'd0;
`endif
    end else begin
      fifo_we_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sample_vld && enable) begin
            word_cnt_q <= 10'd1;
            if (admit) begin
              fifo_we_q  <= 1'b1;
              fifo_din_q <= make_header(frame_cnt_q);
              // First sample waits in the hold register behind the header word(s).
              hold_q     <= make_data(sample_a, sample_b);
              hold_vld_q <= 1'b1;
`ifdef TIMESTAMP_EN
              ts_q       <= ts_now;
              state_q    <= StTs;
`else
              state_q    <= StData;
`endif
            end else begin
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
              overflow_q <= 1'b1;
              state_q    <= StDrop;
            end
          end
        end

        StTs: begin
`ifdef TIMESTAMP_EN
          fifo_we_q  <= 1'b1;
          fifo_din_q <= ts_q;
          if (sample_vld) proto_err_q <= 1'b1;
          state_q    <= StData;
`else
          state_q    <= StIdle;
`endif
        end

        StData: begin
          if (hold_vld_q) begin
            fifo_we_q  <= 1'b1;
            fifo_din_q <= hold_q;
            hold_vld_q <= 1'b0;
            // The port can only carry one word; a sample landing here is lost.
            if (sample_vld) proto_err_q <= 1'b1;
          end else if (sample_vld) begin
            fifo_we_q  <= 1'b1;
            fifo_din_q <= make_data(sample_a, sample_b);
            if (word_cnt_q == LastWord) begin
              word_cnt_q  <= 10'd0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= StIdle;
            end else begin
              word_cnt_q <= word_cnt_q + 10'd1;
            end
          end
        end

        StDrop: begin
          if (sample_vld) begin
            if (word_cnt_q == LastWord) begin
              word_cnt_q  <= 10'd0;
              // Dropped frames still consume an index so the host sees the gap.
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= StIdle;
            end else begin
              word_cnt_q <= word_cnt_q + 10'd1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_we   = fifo_we_q;
  assign fifo_din  = fifo_din_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer with FRAME_LEN=4.
// A transaction-level model predicts, per sample pulse, which words must appear on the FIFO
// port at which clock edge and how the status counters evolve; a compare process checks the
// DUT against it every cycle. Literal expectations pin the model for each directed scenario.
module tb_adc_frame_packer;

  localparam int unsigned FL     = 4;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned MARGIN = 4;
`ifdef TIMESTAMP_EN
  localparam int unsigned HW = 2;
`else
  localparam int unsigned HW = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_vld = 1'b0;
  logic [15:0] sample_a = 16'd0;
  logic [15:0] sample_b = 16'd0;
  logic [9:0]  fifo_count = 10'd0;
  logic        fifo_we;
  logic [31:0] fifo_din;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        proto_err;

  adc_frame_packer #(
    .FRAME_LEN   (FL),
    .FIFO_DEPTH  (DEPTH),
    .FILL_MARGIN (MARGIN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sample_vld (sample_vld),
    .sample_a   (sample_a),
    .sample_b   (sample_b),
    .fifo_count (fifo_count),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the edge just past.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- model ----------------
  typedef struct { int unsigned e; logic [31:0] word; } wr_t;
  typedef struct {
    int unsigned e; logic [15:0] frame; logic [15:0] drop; bit ovf; bit perr;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  st_t cur;
  logic [31:0] dlog[$];

  bit          m_in_frame = 0;
  bit          m_dropping = 0;
  int unsigned m_count = 0;
  int unsigned m_pend = 0;
  logic [15:0] m_frame = 0;
  logic [15:0] m_drop = 0;
  bit          m_ovf = 0;
  bit          m_perr = 0;
  int unsigned m_rst_edge = 0;

  function automatic void push_status(input int unsigned e);
    st_t s;
    s.e = e; s.frame = m_frame; s.drop = m_drop; s.ovf = m_ovf; s.perr = m_perr;
    sq.push_back(s);
  endfunction

  function automatic void push_write(input int unsigned e, input logic [31:0] w);
    wr_t x;
    x.e = e; x.word = w;
    wq.push_back(x);
  endfunction

  function automatic void model_reset(input int unsigned e);
    wr_t keep[$];
    st_t skeep[$];
    foreach (wq[i]) if (wq[i].e < e) keep.push_back(wq[i]);
    wq = keep;
    foreach (sq[i]) if (sq[i].e < e) skeep.push_back(sq[i]);
    sq = skeep;
    m_in_frame = 0; m_dropping = 0; m_count = 0; m_pend = 0;
    m_frame = 0; m_drop = 0; m_ovf = 0; m_perr = 0;
    m_rst_edge = e;
    push_status(e);
  endfunction

  // One sample pulse sampled at rising edge e.
  function automatic void model_sample(input int unsigned e, input logic [15:0] a,
                                       input logic [15:0] b, input logic en,
                                       input logic [9:0] fc);
    int unsigned free_w;
    if (!m_in_frame) begin
      if (!en) return;
      free_w = DEPTH - int'(fc);
      m_in_frame = 1;
      m_count = 1;
      if (free_w >= FL + HW + MARGIN) begin
        m_dropping = 0;
        push_write(e, {16'hA5A5, m_frame});
        if (HW == 2) push_write(e + 1, 32'(e - 1 - m_rst_edge));
        push_write(e + HW, {b, a});
        m_pend = e + HW;
      end else begin
        m_dropping = 1;
        m_pend = 0;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        m_ovf = 1;
      end
    end else if (!m_dropping && e <= m_pend) begin
      m_perr = 1;
    end else begin
      if (!m_dropping) push_write(e, {b, a});
      m_count++;
      if (m_count == FL) begin
        m_in_frame = 0;
        m_frame = m_frame + 16'd1;
      end
    end
    push_status(e);
  endfunction

  // ---------------- compare process ----------------
  bit chk_on = 0;
  always @(negedge clk) begin
    bit  exp_we;
    wr_t w;
    if (chk_on) begin
      while (sq.size() > 0 && sq[0].e <= cyc) cur = sq.pop_front();
      exp_we = (wq.size() > 0 && wq[0].e == cyc);
      check("fifo_we", 32'(fifo_we), 32'(exp_we));
      if (exp_we) begin
        w = wq.pop_front();
        if (fifo_we) check("fifo_din", fifo_din, w.word);
      end
      if (fifo_we) dlog.push_back(fifo_din);
      check("frame_cnt", 32'(frame_cnt), 32'(cur.frame));
      check("drop_cnt", 32'(drop_cnt), 32'(cur.drop));
      check("overflow", 32'(overflow), 32'(cur.ovf));
      check("proto_err", 32'(proto_err), 32'(cur.perr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic rst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b0;
      model_reset(cyc + 1);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    sample_vld = 1'b1; sample_a = a; sample_b = b;
    model_sample(cyc + 1, a, b, enable, fifo_count);
    @(negedge clk);
    sample_vld = 1'b0;
  endtask

  // Sample pulses four cycles apart.
  task automatic send_gap(input logic [15:0] a, input logic [15:0] b);
    send(a, b);
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b0;
  int r0;

  initial begin
    cur.e = 0; cur.frame = 0; cur.drop = 0; cur.ovf = 0; cur.perr = 0;
    rst(2);
    chk_on = 1;
    check("reset_we", 32'(fifo_we), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset_din", fifo_din, 32'd0);

    // 1: nominal, two frames.
    enable = 1'b1;
    b0 = dlog.size();
    for (int i = 0; i < 8; i++) send_gap(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    idle(4);
    check("t1_words", 32'(dlog.size() - b0), 32'(2 * (FL + HW)));
    check("t1_hdr0", dlog[b0], 32'hA5A50000);
    check("t1_d0", dlog[b0 + HW], 32'h20001000);
    check("t1_d3", dlog[b0 + HW + 3], 32'h20031003);
    check("t1_hdr1", dlog[b0 + FL + HW], 32'hA5A50001);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t1_drop_cnt", 32'(drop_cnt), 32'd0);

    // 2: full FIFO drops the frame, then an empty FIFO admits the next one.
    rst(1);
    b0 = dlog.size();
    fifo_count = 10'd1020;
    send_gap(16'h3000, 16'h4000);
    fifo_count = 10'd0;
    for (int i = 1; i < 4; i++) send_gap(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    idle(2);
    check("t2_no_writes", 32'(dlog.size() - b0), 32'd0);
    check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t2_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) send_gap(16'h5000 + 16'(i), 16'h6000 + 16'(i));
    idle(2);
    check("t2_hdr", dlog[b0], 32'hA5A50001);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // 3: enable falls mid-frame; frame completes, later samples ignored.
    rst(1);
    b0 = dlog.size();
    enable = 1'b1;
    send_gap(16'h0001, 16'h0101);
    send_gap(16'h0002, 16'h0102);
    enable = 1'b0;
    send_gap(16'h0003, 16'h0103);
    send_gap(16'h0004, 16'h0104);
    send_gap(16'h0005, 16'h0105);
    idle(4);
    check("t3_words", 32'(dlog.size() - b0), 32'(FL + HW));
    check("t3_last", dlog[b0 + HW + 3], 32'h01040004);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t3_perr", 32'(proto_err), 32'd0);

    // 4: back-to-back pulses at frame start.
    rst(1);
    b0 = dlog.size();
    enable = 1'b1;
    @(negedge clk);
    sample_vld = 1'b1; sample_a = 16'hAA01; sample_b = 16'hBB01;
    model_sample(cyc + 1, sample_a, sample_b, enable, fifo_count);
    @(negedge clk);
    sample_a = 16'hAA02; sample_b = 16'hBB02;
    model_sample(cyc + 1, sample_a, sample_b, enable, fifo_count);
    @(negedge clk);
    sample_vld = 1'b0;
    idle(3);
    for (int i = 3; i < 6; i++) send_gap(16'hAA00 + 16'(i), 16'hBB00 + 16'(i));
    idle(2);
    check("t4_perr", 32'(proto_err), 32'd1);
    check("t4_first", dlog[b0 + HW], 32'hBB01AA01);
    check("t4_second", dlog[b0 + HW + 1], 32'hBB03AA03);
    check("t4_words", 32'(dlog.size() - b0), 32'(FL + HW));

    // 5: reset mid-frame.
    send_gap(16'h7001, 16'h8001);
    send_gap(16'h7002, 16'h8002);
    rst(1);
    check("t5_we", 32'(fifo_we), 32'd0);
    check("t5_din", fifo_din, 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_perr", 32'(proto_err), 32'd0);
    b0 = dlog.size();
    for (int i = 0; i < 4; i++) send_gap(16'h7100 + 16'(i), 16'h8100 + 16'(i));
    idle(2);
    check("t5_hdr", dlog[b0], 32'hA5A50000);

`ifdef TIMESTAMP_EN
    // 6: timestamp counter reads 100 on the admitting edge.
    rst(1);
    r0 = cyc;
    b0 = dlog.size();
    while (cyc < r0 + 99) @(negedge clk);
    for (int i = 0; i < 4; i++) send_gap(16'h9000 + 16'(i), 16'h9100 + 16'(i));
    idle(2);
    check("t6_hdr", dlog[b0], 32'hA5A50000);
    check("t6_ts", dlog[b0 + 1], 32'h00000064);
    check("t6_d0", dlog[b0 + 2], 32'h91009000);
`else
    r0 = 0;
`endif

    idle(4);
    check("pending_writes", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
